seq_loop_ctrl: RTL
==================

SEQ_LOOP_CTRL -- requirements
Module: seq_loop_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the trip count and iteration index.
REQ-002 Parameter QUIT_N, default 16, SHALL set the number of early-quit request lines (1..16).
REQ-003 clock  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL be the loop launch request, sampled only in IDLE.
REQ-006 trip_count  in  CNT_W  SHALL be the iteration count, latched when start is accepted.
REQ-007 body_start  out  1  SHALL be a one-cycle pulse launching one loop-body iteration.
REQ-008 body_done  in  1  SHALL be the body completion strobe, sampled only in ITER_WAIT.
REQ-009 quit_req  in  QUIT_N  SHALL carry the early-exit conditions, sampled only in ITER_WAIT.
REQ-010 busy  out  1  SHALL be high in every state except IDLE.
REQ-011 cur_state  out  3  SHALL expose the FSM state encoding.
REQ-012 iter_idx  out  CNT_W  SHALL be the count of completed iterations.
REQ-013 quit_flag  out  1  and quit_src  out  4  SHALL report early exit and the winning quit line.
REQ-014 finish  out  1  SHALL pulse for exactly one cycle in FINISH.
REQ-015 perf_cycles  out  32  SHALL report the cycle count of the last run (see Configuration).

Function
REQ-016 States: IDLE=0, PRE=1, ITER_START=2, ITER_WAIT=3, ITER_END=4, POST=5, FINISH=6; code 7 SHALL return to IDLE.
REQ-017 IDLE: start=1 SHALL latch trip_count, clear iter_idx/quit_flag/quit_src, go to PRE.
REQ-018 PRE: one cycle; trip=0 -> POST, else -> ITER_START.
REQ-019 ITER_START: body_start=1 for that cycle only; -> ITER_WAIT.
REQ-020 ITER_WAIT: any quit_req bit set -> latch lowest set index into quit_src, set quit_flag, -> POST; else body_done=1 -> ITER_END; else hold.
REQ-021 Simultaneous quit_req and body_done SHALL take the quit path, with iter_idx not incremented.
REQ-022 ITER_END: iter_idx SHALL increment; new value == latched trip -> POST, else -> ITER_START.
REQ-023 POST: one cycle -> FINISH; FINISH: finish=1, one cycle -> IDLE.
REQ-024 start outside IDLE SHALL be ignored; start held high in FINISH's successor IDLE cycle SHALL relaunch.
REQ-025 trip_count up to 2^CNT_W-1 SHALL be supported without wrap; iter_idx SHALL hold after the run until the next accepted start.
REQ-026 Latency with body_done one cycle after body_start: 3 cycles per iteration, total 3*trip+3 cycles from the start-sample cycle to finish.

Reset
REQ-027 reset low SHALL force IDLE immediately; body_start, busy, finish, quit_flag=0; cur_state=0; iter_idx, quit_src, perf_cycles=0.
REQ-028 Reset mid-run SHALL abandon the run, without finish being pulsed.

Configuration
REQ-029 With SEQ_LOOP_CTRL_PERF_EN defined, perf_cycles SHALL count cycles from PRE through FINISH inclusive, clear on accepted start, saturate at 2^32-1, and hold in IDLE.
REQ-030 Without SEQ_LOOP_CTRL_PERF_EN, perf_cycles SHALL be constant 0 and the counter SHALL not be synthesised.

Structure
REQ-031 Package seq_loop_pkg SHALL hold the 3-bit state typedef, the state constants, and the QUIT_N maximum (16).
REQ-032 Sub-module seq_loop_quit_enc SHALL implement the QUIT_N-to-4 lowest-index priority encoder with a valid flag.

Verification
REQ-033 trip=3, body_done one cycle after each body_start -> 3 body_start pulses, iter_idx=3, finish at cycle 12 after start, perf_cycles=12 (PERF_EN).
REQ-034 trip=0 -> no body_start, finish at cycle 3, iter_idx=0, perf_cycles=3.
REQ-035 trip=5, quit_req=16'h0048 in the 2nd ITER_WAIT -> quit_flag=1, quit_src=3, iter_idx=1, finish 2 cycles later.
REQ-036 body_done and quit_req[0] both high in the same ITER_WAIT -> quit path taken, iter_idx not incremented, quit_src=0.
REQ-037 reset asserted during ITER_WAIT of trip=4 -> outputs at reset values immediately, no finish pulse; a fresh start with trip=1 then completes normally.
REQ-038 start pulsed while busy -> ignored, with trip_count changes not captured.

Source files
------------

// File: rtl/seq_loop_pkg.sv
// -----------------------------------------------------------------------------
// seq_loop_pkg
// Shared definitions for the sequenced loop controller:
//   - state_t      : 3-bit FSM state encoding, also exposed on cur_state
//   - QUIT_N_MAX   : largest supported number of early-quit request lines
//   - sat_inc32    : saturating 32-bit increment used by the cycle counter
// -----------------------------------------------------------------------------
package seq_loop_pkg;

    localparam int QUIT_N_MAX = 16;
    localparam int STATE_W    = 3;

    // Code 7 is not a working state; the FSM falls back to IDLE from it.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_PRE        = 3'd1,
        ST_ITER_START = 3'd2,
        ST_ITER_WAIT  = 3'd3,
        ST_ITER_END   = 3'd4,
        ST_POST       = 3'd5,
        ST_FINISH     = 3'd6,
        ST_RSVD       = 3'd7
    } state_t;

    // Stops at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/seq_loop_quit_enc.sv
// -----------------------------------------------------------------------------
// seq_loop_quit_enc
// Lowest-index-wins priority encoder for the early-quit request lines.
// Ports:
//   req   in  QUIT_N  quit request lines, bit 0 has the highest priority
//   src   out 4       index of the lowest set request bit (0 when none set)
//   valid out 1       at least one request bit is set
// -----------------------------------------------------------------------------
import seq_loop_pkg::*;

module seq_loop_quit_enc #(
    parameter int QUIT_N = QUIT_N_MAX
) (
    input  logic [QUIT_N-1:0] req,
    output logic [3:0]        src,
    output logic              valid
);

    // Walk from the top index down so the last hit, the lowest set bit,
    // is the one that sticks.
    always_comb begin
        src   = 4'd0;
        valid = 1'b0;
        for (int i = QUIT_N - 1; i >= 0; i--) begin
            if (req[i]) begin
                src   = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_loop_ctrl.sv
// -----------------------------------------------------------------------------
// seq_loop_ctrl
// Sequences a counted loop: PRE, then trip_count iterations of
// (ITER_START -> ITER_WAIT -> ITER_END), then POST and a one-cycle FINISH.
// Any quit request seen while waiting on the body ends the loop early.
//
// Optional feature: define SEQ_LOOP_CTRL_PERF_EN to build the run-length
// cycle counter behind perf_cycles; otherwise perf_cycles is tied to 0.
//
// Ports:
//   clock        in   1      single clock, rising edge
//   reset        in   1      asynchronous reset, active low
//   start        in   1      launch request, only looked at in IDLE
//   trip_count   in   CNT_W  iteration count, captured on accepted start
//   body_start   out  1      one-cycle pulse launching one body iteration
//   body_done    in   1      body completion strobe, looked at in ITER_WAIT
//   quit_req     in   QUIT_N early-exit lines, looked at in ITER_WAIT
//   busy         out  1      high in every state except IDLE
//   cur_state    out  3      current FSM state code
//   iter_idx     out  CNT_W  completed iterations of the current/last run
//   quit_flag    out  1      last run ended through a quit request
//   quit_src     out  4      lowest quit line that ended the last run
//   finish       out  1      one-cycle pulse in FINISH
//   perf_cycles  out  32     cycles spent from PRE through FINISH
// -----------------------------------------------------------------------------
import seq_loop_pkg::*;

module seq_loop_ctrl #(
    parameter int CNT_W  = 16,
    parameter int QUIT_N = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  trip_count,
    output logic              body_start,
    input  logic              body_done,
    input  logic [QUIT_N-1:0] quit_req,
    output logic              busy,
    output logic [2:0]        cur_state,
    output logic [CNT_W-1:0]  iter_idx,
    output logic              quit_flag,
    output logic [3:0]        quit_src,
    output logic              finish,
    output logic [31:0]       perf_cycles
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   trip_q;
    logic [CNT_W-1:0]   iter_q;
    logic [CNT_W-1:0]   iter_next;
    logic               quit_flag_q;
    logic [3:0]         quit_src_q;

    logic               load_run;
    logic               take_quit;
    logic               iter_inc;

    logic [3:0]         enc_src;
    logic               enc_valid;

    seq_loop_quit_enc #(
        .QUIT_N (QUIT_N)
    ) u_quit_enc (
        .req   (quit_req),
        .src   (enc_src),
        .valid (enc_valid)
    );

    // The index never exceeds the captured trip, so this cannot wrap even
    // for a trip of all ones.
    assign iter_next = iter_q + CNT_W'(1);

    // State register; reset drops straight back to IDLE, abandoning any run.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs. A quit request in ITER_WAIT outranks a
    // simultaneous body_done so the aborted iteration is never counted.
    always_comb begin
        state_d    = state_q;
        body_start = 1'b0;
        finish     = 1'b0;
        busy       = 1'b1;
        load_run   = 1'b0;
        take_quit  = 1'b0;
        iter_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load_run = 1'b1;
                    state_d  = ST_PRE;
                end
            end
            ST_PRE: begin
                state_d = (trip_q == '0) ? ST_POST : ST_ITER_START;
            end
            ST_ITER_START: begin
                body_start = 1'b1;
                state_d    = ST_ITER_WAIT;
            end
            ST_ITER_WAIT: begin
                if (enc_valid) begin
                    take_quit = 1'b1;
                    state_d   = ST_POST;
                end else if (body_done) begin
                    state_d = ST_ITER_END;
                end
            end
            ST_ITER_END: begin
                iter_inc = 1'b1;
                state_d  = (iter_next == trip_q) ? ST_POST : ST_ITER_START;
            end
            ST_POST: begin
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run context: trip and status are cleared on launch and then held after
    // the run so software can read them back from IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trip_q      <= '0;
            iter_q      <= '0;
            quit_flag_q <= 1'b0;
            quit_src_q  <= 4'd0;
        end else begin
            if (load_run) begin
                trip_q      <= trip_count;
                iter_q      <= '0;
                quit_flag_q <= 1'b0;
                quit_src_q  <= 4'd0;
            end
            if (iter_inc) begin
                iter_q <= iter_next;
            end
            if (take_quit) begin
                quit_flag_q <= 1'b1;
                quit_src_q  <= enc_src;
            end
        end
    end

`ifdef SEQ_LOOP_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Counts every non-IDLE cycle of a run, restarts on launch and freezes
    // in IDLE so the last run's length stays visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_q <= 32'd0;
        end else if (load_run) begin
            perf_q <= 32'd0;
        end else if (state_q != ST_IDLE) begin
            perf_q <= sat_inc32(perf_q);
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

    assign cur_state = state_q;
    assign iter_idx  = iter_q;
    assign quit_flag = quit_flag_q;
    assign quit_src  = quit_src_q;

endmodule
